sm_comb_cs_ns_ol: RTL and testbench
===================================

SM_COMB_CS_NS_OL -- requirements
Module: sm_comb_cs_ns_ol

Interface
REQ-001 Parameter STYLE, default 0: selects the internal FSM coding partition. 0 = combined current-state, next-state and output logic in one process; 1 = combined current-state and next-state, separate output logic; 2 = combined next-state and output logic, separate current-state register; 3 = fully separate current-state, next-state and output logic.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 Port control, input, 1 bit: advance request, sampled on rising clk.
REQ-005 Port y, output, 2 bits: current state code.

Function
REQ-006 The FSM SHALL have four states: S0 (code 2'd0), S1 (2'd1), S2 (2'd2) and S3 (2'd3).
REQ-007 On a rising clk with control=1, the FSM SHALL advance: S0->S1, S1->S2, S2->S3, S3->S0 (wrap-around).
REQ-008 On a rising clk with control=0, the FSM SHALL hold its current state.
REQ-009 Output y SHALL be a Moore output equal to the current state code, with no dependence on control.
REQ-010 y SHALL reflect a state change within the same cycle as the rising edge that causes it: one-clock latency from a control sample to the y change, and no additional register stage.
REQ-011 For STYLE 1 and 3, y SHALL be decoded combinationally from the state register.
REQ-012 For STYLE 0 and 2, y SHALL be assigned in the same process as the next state, and SHALL remain cycle-identical to STYLE 1 and 3.
REQ-013 All STYLE values SHALL produce bit-identical y for identical clk, reset and control sequences at every clock edge.
REQ-014 An undefined STYLE value SHALL fall back to STYLE 0 behaviour.
REQ-015 Any illegal or unknown internal state SHALL recover to S0 on the next rising clk, with y=2'd0.
REQ-016 y SHALL never be X or Z after the first reset assertion.

Reset
REQ-017 When reset=0, the state SHALL go to S0 and y to 2'd0 immediately, independent of clk.
REQ-018 While reset=0, the FSM SHALL ignore control and hold S0.
REQ-019 Reset asserted mid-sequence (any state) SHALL force S0 asynchronously.
REQ-020 After reset is deasserted, the first advance SHALL occur on the first rising clk that samples control=1.
REQ-021 Reset deassertion coincident with a rising clk SHALL leave the FSM in S0 for that edge.

Structure
REQ-022 A shared package sm_4way_pkg SHALL hold the 2-bit state typedef, the constants S0..S3 and the STYLE constants.
REQ-023 A combinational sub-module sm_4way_next SHALL compute the next state from the inputs {state, control}.
REQ-024 The STYLE 1 and 3 branches SHALL reuse sm_4way_next.
REQ-025 All STYLE branches SHALL be selected by a generate construct within sm_comb_cs_ns_ol.

Verification
REQ-026 Scenario (reset): pulse reset low mid-cycle while in S2 -> y=0 immediately, without waiting for clk.
REQ-027 Scenario (hold): control=0 for 4 clocks after reset -> y stays 0.
REQ-028 Scenario (advance and wrap): control=1 for 4 clocks -> y goes 1,2,3,0 on successive rising edges; then control=0 for 4 clocks -> y stays 0.
REQ-029 Scenario (partial advance then hold): control=1 for 2 clocks, then 0 for 3 clocks -> y goes 1,2, then holds 2.
REQ-030 Scenario (style equivalence): instantiate STYLE 0..3 side by side with a random control sequence of 200 cycles plus random resets -> all four y outputs equal at every falling clk.
REQ-031 Scenario (reset during advance): control=1 held with reset asserted while in S3 -> y=0; after release, y goes 1 on the next rising clk.

Source files
------------

// File: rtl/sm_4way_pkg.sv
// Shared definitions for the four-state advance/hold FSM: state codes,
// coding-style selectors and the next-state rule used by every style.
package sm_4way_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  localparam int STYLE_CS_NS_OL = 0;  // one process: register, next state, output
  localparam int STYLE_CS_NS    = 1;  // register+next state, separate output decode
  localparam int STYLE_NS_OL    = 2;  // next state+output, separate register
  localparam int STYLE_SPLIT    = 3;  // three separate processes

  // Any code outside S0..S3 (X/Z after power-up) recovers to S0.
  function automatic state_t next_state(input state_t s, input logic control);
    state_t n;
    n = S0;
    case (s)
      S0:      n = control ? S1 : S0;
      S1:      n = control ? S2 : S1;
      S2:      n = control ? S3 : S2;
      S3:      n = control ? S0 : S3;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sm_comb_cs_ns_ol_if.sv
// Control/status bundle for the four-state FSM: the advance request in,
// the current state code out.
interface sm_comb_cs_ns_ol_if;

  logic       control;
  logic [1:0] y;

  modport master (output control, input  y);
  modport slave  (input  control, output y);

endinterface

// File: rtl/sm_4way_next.sv
// Combinational next-state logic for the four-state advance/hold FSM.
module sm_4way_next
  import sm_4way_pkg::*;
(
  input  state_t state_i,
  input  logic   control_i,
  output state_t state_o
);

  always_comb begin
    state_o = next_state(state_i, control_i);
  end

endmodule

// File: rtl/sm_comb_cs_ns_ol.sv
// Four-state advance/hold FSM, coded in one of four process partitions
// selected by STYLE; every partition yields the same cycle behaviour on y.
module sm_comb_cs_ns_ol
  import sm_4way_pkg::*;
#(
  parameter int STYLE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       control,
  output logic [1:0] y
);

  generate
    if (STYLE == STYLE_CS_NS) begin : g_cs_ns
      state_t state_q;
      state_t state_d;

      sm_4way_next u_next (.state_i(state_q), .control_i(control), .state_o(state_d));

      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of process evaluation order.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S0;
        else        state_q <= state_d;
      end

      always_comb begin
        y = state_q;
      end

    end else if (STYLE == STYLE_NS_OL) begin : g_ns_ol
      state_t state_q;
      state_t state_d;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S0;
        else        state_q <= state_d;
      end

      // NOTE: every always_comb output gets a value on every path, so no
      // latch can be inferred.
      always_comb begin
        state_d = next_state(state_q, control);
        y       = state_q;
      end

    end else if (STYLE == STYLE_SPLIT) begin : g_split
      state_t state_q;
      state_t state_d;
      state_t next_w;

      sm_4way_next u_next (.state_i(state_q), .control_i(control), .state_o(next_w));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S0;
        else        state_q <= state_d;
      end

      always_comb begin
        state_d = next_w;
      end

      always_comb begin
        y = state_q;
      end

    end else begin : g_cs_ns_ol
      // STYLE 0 and any undefined STYLE value. The output register is
      // loaded with the same next state, so it tracks state_q exactly.
      state_t     state_q;
      logic [1:0] y_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q <= S0;
          y_q     <= S0;
        end else begin
          state_q <= next_state(state_q, control);
          y_q     <= next_state(state_q, control);
        end
      end

      assign y = y_q;
    end
  endgenerate

endmodule

// File: tb/tb_sm_comb_cs_ns_ol.sv
// Directed and style-equivalence checks for the four-state advance/hold FSM.
module tb_sm_comb_cs_ns_ol;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] y1, y2, y3, y7;
  logic [1:0] model;
  logic       rnd_rst;
  logic       rnd_ctrl;
  int         total = 0;
  int         bad   = 0;

  sm_comb_cs_ns_ol_if bus ();

  always #5 clk = ~clk;

  sm_comb_cs_ns_ol #(.STYLE(0)) u_dut0 (.clk(clk), .reset(reset), .control(bus.control), .y(bus.y));
  sm_comb_cs_ns_ol #(.STYLE(1)) u_dut1 (.clk(clk), .reset(reset), .control(bus.control), .y(y1));
  sm_comb_cs_ns_ol #(.STYLE(2)) u_dut2 (.clk(clk), .reset(reset), .control(bus.control), .y(y2));
  sm_comb_cs_ns_ol #(.STYLE(3)) u_dut3 (.clk(clk), .reset(reset), .control(bus.control), .y(y3));
  sm_comb_cs_ns_ol #(.STYLE(7)) u_dut7 (.clk(clk), .reset(reset), .control(bus.control), .y(y7));

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive control at the falling edge, sample y 1 ns after the rising edge.
  task automatic step(input logic c, input logic [1:0] exp, input string tag);
    @(negedge clk);
    bus.control = c;
    @(posedge clk);
    #1;
    check(tag, bus.y, exp);
  endtask

  initial begin
    reset       = 1'b0;
    bus.control = 1'b0;
    #1;
    check("reset_y0", bus.y, 2'd0);
    check("reset_y3", y3, 2'd0);

    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, "hold_after_reset");

    step(1'b1, 2'd1, "adv_s1");
    step(1'b1, 2'd2, "adv_s2");
    step(1'b1, 2'd3, "adv_s3");
    step(1'b1, 2'd0, "adv_wrap");
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, "hold_after_wrap");

    step(1'b1, 2'd1, "partial_s1");
    step(1'b1, 2'd2, "partial_s2");
    for (int i = 0; i < 3; i++) step(1'b0, 2'd2, "partial_hold");

    // Asynchronous reset pulse mid-cycle while in S2.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_s2_y0", bus.y, 2'd0);
    check("async_rst_s2_y1", y1, 2'd0);
    check("async_rst_s2_y2", y2, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("after_async_rst", bus.y, 2'd0);

    // Reset during advance with control held high.
    step(1'b1, 2'd1, "radv_s1");
    step(1'b1, 2'd2, "radv_s2");
    step(1'b1, 2'd3, "radv_s3");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("radv_rst_in_s3", bus.y, 2'd0);
    @(posedge clk);
    #1;
    check("radv_rst_ignores_ctrl", bus.y, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("radv_first_adv", bus.y, 2'd1);

    // Style equivalence against a reference model, with random resets.
    @(negedge clk);
    reset = 1'b0;
    model = 2'd0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("eq_style0", bus.y, model);
      check("eq_style1", y1, model);
      check("eq_style2", y2, model);
      check("eq_style3", y3, model);
      check("eq_style_undef", y7, model);
      rnd_rst     = ($urandom_range(0, 15) == 0);
      rnd_ctrl    = 1'($urandom_range(0, 1));
      reset       = ~rnd_rst;
      bus.control = rnd_ctrl;
      if (rnd_rst) model = 2'd0;
      @(posedge clk);
      if (!rnd_rst && rnd_ctrl) model = model + 2'd1;
    end
    @(negedge clk);
    check("eq_final", bus.y, model);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
